// File: rtl/spike_pkg.sv
// Shared constants for the spike packet path: packet layout and reserved addresses.
package spike_pkg;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned PACKET_W = 2 * ADDR_W;

    localparam int unsigned ORIGIN_MSB = PACKET_W - 1;
    localparam int unsigned ORIGIN_LSB = ADDR_W;
    localparam int unsigned DEST_MSB   = ADDR_W - 1;
    localparam int unsigned DEST_LSB   = 0;

    localparam logic [ADDR_W-1:0] INVALID_ADDR = 12'hFFF;

endpackage

// File: rtl/spike_fifo.sv
// Synchronous FIFO with wrapping pointers and an occupancy counter.
module spike_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
        end
        if (do_pop) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = LVL_W'(level_q + 1'b1);
            2'b01:   level_d = LVL_W'(level_q - 1'b1);
            default: level_d = level_q;
        endcase
    end

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/spike_receiver.sv
// Buffers inbound spike packets and strobes the addressed local MAC unit, counting non-local drops.
module spike_receiver #(
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned ADDR_W      = spike_pkg::ADDR_W,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          clear,
    input  logic [2*ADDR_W-1:0]           packet_in,
    input  logic                          packet_valid,
    output logic                          packet_ready,
    output logic [ADDR_W-1:0]             dispatch_source,
    output logic [NUM_NEURONS-1:0]        dispatch_valid,
    output logic [15:0]                   drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PKT_W = 2 * ADDR_W;

    logic                   fifo_full, fifo_empty;
    logic                   pop;
    logic [PKT_W-1:0]       head;
    logic [ADDR_W-1:0]      head_origin, head_dest, idx;
    logic                   is_local;

    logic [ADDR_W-1:0]      dispatch_source_q, dispatch_source_d;
    logic [NUM_NEURONS-1:0] dispatch_valid_q, dispatch_valid_d;
    logic [15:0]            drop_count_q, drop_count_d;

    assign packet_ready = !fifo_full;
    // Pop is decided from registered occupancy, so it never waits on this cycle's push.
    assign pop          = !fifo_empty && !clear;

    spike_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (packet_valid && packet_ready),
        .pop   (pop),
        .wdata (packet_in),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign head_origin = head[PKT_W-1 -: ADDR_W];
    assign head_dest   = head[ADDR_W-1:0];
    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign idx         = ADDR_W'(head_dest - ADDR_W'(BASE_ADDR));
    assign is_local    = (idx < ADDR_W'(NUM_NEURONS));

    always_comb begin
        dispatch_valid_d  = '0;
        dispatch_source_d = dispatch_source_q;
        drop_count_d      = drop_count_q;
        if (pop) begin
            if (is_local) begin
                dispatch_source_d = head_origin;
                dispatch_valid_d  = NUM_NEURONS'(1) << idx;
            end else if (drop_count_q != 16'hFFFF) begin
                drop_count_d = 16'(drop_count_q + 16'd1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            dispatch_source_q <= '0;
            dispatch_valid_q  <= '0;
            drop_count_q      <= '0;
        end else begin
            dispatch_source_q <= dispatch_source_d;
            dispatch_valid_q  <= dispatch_valid_d;
            drop_count_q      <= drop_count_d;
        end
    end

    assign dispatch_source = dispatch_source_q;
    assign dispatch_valid  = dispatch_valid_q;
    assign drop_count      = drop_count_q;

endmodule

// File: tb/tb_spike_receiver.sv
// Scoreboard bench for spike_receiver: queue-level reference model, directed scenarios plus random traffic.
module tb_spike_receiver;

    localparam int N     = 10;
    localparam int DEPTH = 8;
    localparam int BASE  = 0;

    logic        CLK = 1'b0;
    logic        reset, clear, packet_valid, packet_ready;
    logic [23:0] packet_in;
    logic [11:0] dispatch_source;
    logic [9:0]  dispatch_valid;
    logic [15:0] drop_count;
    logic [3:0]  fifo_level;

    always #5 CLK = ~CLK;

    spike_receiver #(
        .NUM_NEURONS (N),
        .ADDR_W      (12),
        .FIFO_DEPTH  (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .CLK             (CLK),
        .reset           (reset),
        .clear           (clear),
        .packet_in       (packet_in),
        .packet_valid    (packet_valid),
        .packet_ready    (packet_ready),
        .dispatch_source (dispatch_source),
        .dispatch_valid  (dispatch_valid),
        .drop_count      (drop_count),
        .fifo_level      (fifo_level)
    );

    typedef struct {
        int         cyc;
        logic [11:0] src;
        logic [9:0]  dv;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] model_q[$];
    int          model_drops = 0;
    logic [11:0] model_src   = '0;
    int          cyc         = 0;
    bit          live        = 1'b0;
    int          vectors     = 0;
    int          miscompares = 0;

    // Reference model: a packet queue, advanced once per clock edge.
    always @(posedge CLK) begin
        logic [23:0] p;
        int          dest;
        bit          pop_now, push_now;
        cyc++;
        if (reset) begin
            model_q.delete();
            model_drops = 0;
            model_src   = '0;
            live        = 1'b1;
        end else begin
            pop_now  = (model_q.size() > 0) && !clear;
            push_now = packet_valid && (model_q.size() < DEPTH);
            if (pop_now) begin
                p    = model_q.pop_front();
                dest = int'(p[11:0]);
                if (dest >= BASE && dest < BASE + N) begin
                    exp_q.push_back('{cyc, p[23:12], 10'(1 << (dest - BASE))});
                    model_src = p[23:12];
                end else if (model_drops < 65535) begin
                    model_drops++;
                end
            end
            if (push_now) model_q.push_back(packet_in);
        end
    end

    // Monitor: every cycle either the scheduled pulse appears or nothing does.
    always @(negedge CLK) begin
        exp_t e;
        if (live) begin
            vectors++;
            if (dispatch_source !== model_src) begin
                miscompares++;
                $display("FAIL source cyc=%0d got=%0d want=%0d", cyc, dispatch_source, model_src);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                vectors++;
                if (dispatch_valid !== e.dv || dispatch_source !== e.src) begin
                    miscompares++;
                    $display("FAIL pulse cyc=%0d got=%b/%0d want=%b/%0d",
                             cyc, dispatch_valid, dispatch_source, e.dv, e.src);
                end
            end else begin
                vectors++;
                if (dispatch_valid !== '0) begin
                    miscompares++;
                    $display("FAIL spurious cyc=%0d got=%b want=0", cyc, dispatch_valid);
                end
            end
        end
    end

    task automatic step(input bit r, input bit c, input bit v, input logic [23:0] p);
        @(negedge CLK);
        if (live) begin
            vectors++;
            if (packet_ready !== (model_q.size() < DEPTH)) begin
                miscompares++;
                $display("FAIL ready cyc=%0d got=%b want=%b", cyc, packet_ready, model_q.size() < DEPTH);
            end
            vectors++;
            if (fifo_level !== 4'(model_q.size())) begin
                miscompares++;
                $display("FAIL level cyc=%0d got=%0d want=%0d", cyc, fifo_level, model_q.size());
            end
            vectors++;
            if (drop_count !== 16'(model_drops)) begin
                miscompares++;
                $display("FAIL drops cyc=%0d got=%0d want=%0d", cyc, drop_count, model_drops);
            end
        end
        reset        = r;
        clear        = c;
        packet_valid = v;
        packet_in    = p;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    function automatic logic [23:0] rand_pkt();
        logic [11:0] org, dst;
        int          sel;
        org = 12'($urandom);
        sel = int'($urandom_range(0, 9));
        if (sel < 7)       dst = 12'($urandom_range(0, N - 1));
        else if (sel == 7) dst = 12'hFFF;
        else if (sel == 8) dst = 12'($urandom_range(N, 4095));
        else               dst = 12'(N);
        return {org, dst};
    endfunction

    initial begin
        reset        = 1'b1;
        clear        = 1'b0;
        packet_valid = 1'b0;
        packet_in    = '0;
        step(1'b1, 1'b0, 1'b0, 24'h0);
        step(1'b1, 1'b0, 1'b1, {12'd5, 12'd1});
        step(1'b0, 1'b0, 1'b0, 24'h0);
        idle(2);

        // Single local packet to neuron 7.
        step(1'b0, 1'b0, 1'b1, {12'd3, 12'd7});
        idle(4);

        // Two non-local packets, one just past the local range.
        step(1'b0, 1'b0, 1'b1, {12'd2, 12'hFFB});
        step(1'b0, 1'b0, 1'b1, {12'd2, 12'd10});
        idle(4);

        // Backpressure: fill under clear, ninth packet waits for space.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, {12'(100 + i), 12'(i % N)});
        step(1'b0, 1'b0, 1'b1, {12'd108, 12'd8});
        step(1'b0, 1'b0, 1'b1, {12'd108, 12'd8});
        idle(12);

        // Streaming one packet per cycle.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, {12'(200 + i), 12'(i % N)});
        idle(4);

        // Clear stall with two buffered packets.
        step(1'b0, 1'b1, 1'b1, {12'd301, 12'd4});
        step(1'b0, 1'b1, 1'b1, {12'd302, 12'd9});
        step(1'b0, 1'b1, 1'b0, 24'h0);
        idle(5);

        // Reset with traffic buffered and drops counted.
        step(1'b1, 1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b0, 1'b0, 24'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, {12'd7, 12'h800});
        idle(3);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, {12'(400 + i), 12'(i)});
        step(1'b1, 1'b1, 1'b1, {12'd499, 12'd2});
        step(1'b0, 1'b0, 1'b0, 24'h0);
        idle(6);

        // Randomised traffic with occasional clear and reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 12),
                 ($urandom_range(0, 99) < 75), rand_pkt());
        end
        idle(20);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spike_receiver.md
# spike_receiver

Inbound end of the spike packet path. Accepts 24-bit spike packets {origin[23:12], destination[11:0]} from the network interface or the NoC router over a valid/ready handshake and buffers them in a small FIFO. It then dispatches one packet per cycle as a source-address strobe to the MAC unit of the addressed local neuron. Packets addressed outside the local neuron range are dropped and counted.

## Interface
Parameters:
- NUM_NEURONS, 10, number of local neurons and MAC units.
- ADDR_W, 12, neuron address width.
- FIFO_DEPTH, 8, packet buffer depth; power of two, at least 2.
- BASE_ADDR, 0, address of local neuron 0. Local range is [BASE_ADDR, BASE_ADDR+NUM_NEURONS).

Ports (synchronous reset, active-high, on the one clock CLK):
- CLK  in  1  clock.
- reset  in  1  synchronous active-high reset.
- clear  in  1  timestep boundary pulse, shared with the MAC units.
- packet_in  in  2*ADDR_W  incoming packet: origin in [23:12], destination in [11:0].
- packet_valid  in  1  packet_in is valid.
- packet_ready  out  1  receiver can accept a packet this cycle.
- dispatch_source  out  ADDR_W  origin address presented to the MACs.
- dispatch_valid  out  NUM_NEURONS  one-hot strobe; bit i targets MAC i.
- drop_count  out  16  saturating count of non-local packets.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Accept occurs when packet_valid && packet_ready. packet_ready = (fifo_level != FIFO_DEPTH) and is combinational from registered state.
- The FIFO uses read and write pointers that wrap modulo FIFO_DEPTH, plus an occupancy counter.
- Pop condition: FIFO not empty && !clear. On a pop the head packet is decoded:
  - idx = destination - BASE_ADDR, computed at ADDR_W width with no sign extension.
  - Local (idx < NUM_NEURONS): on the next edge dispatch_source <= origin and dispatch_valid <= (1 << idx).
  - Non-local, including 12'hFFF: dispatch_valid <= 0 and dispatch_source holds its value. drop_count increments and saturates at 16'hFFFF.
- No pop in a cycle: dispatch_valid <= 0 and dispatch_source holds its value.
- Push and pop in the same cycle: occupancy is unchanged and both pointers advance. This is allowed when full, because the pop is decided from the registered count; packet_ready still reads 0 that cycle, so no push actually happens when full.
- Empty FIFO with a push: there is no bypass. The packet is dispatched no earlier than the cycle after it is written.
- clear high: the pop stalls while the MACs reset, and accepts continue. Buffered packets are not flushed. They dispatch into the new timestep.
- reset: pointers, occupancy, dispatch_valid, dispatch_source and drop_count all go to 0. Any packet presented during the reset cycle is not accepted, because reset has priority.

## Timing
- Reset values: packet_ready=1 (the cycle after reset deasserts), dispatch_valid=0, dispatch_source=0, drop_count=0, fifo_level=0.
- Latency: a packet accepted at edge N is popped at edge N+1 if no clear and no older packets. dispatch_valid is then high for the cycle after N+1.
- Throughput is one packet per cycle in steady state.
- dispatch_valid is a single-cycle pulse per packet. Back-to-back packets give consecutive pulses.
- drop_count and fifo_level update on the same edge as the pop or push that causes them.

## Structure
- Shared package spike_pkg:
  - PACKET_W=24 and ADDR_W=12.
  - Origin and destination field slice constants.
  - INVALID_ADDR=12'hFFF.
- One sub-module, spike_fifo: a parameterised synchronous FIFO with push, pop, full, empty, level, wrap pointers and the same reset. Decode, dispatch and the drop counter live in spike_receiver.

## Test plan
- Single local packet: after reset, push {12'd3,12'd7} at edge N. Expect dispatch_valid=10'b0010000000 and dispatch_source=3 for exactly one cycle after edge N+1, then fifo_level=0.
- Non-local drop: push {12'd2,12'hFFB} then {12'd2,12'd10}. Expect no dispatch_valid pulse, drop_count=2 and fifo_level=0.
- Backpressure: hold clear=1 and push 9 packets. Expect packet_ready=0 after 8 accepts and fifo_level=8. Release clear: expect 8 consecutive one-hot pulses in FIFO order and packet_ready=1 after the first pop.
- Simultaneous push/pop: stream one packet per cycle to destinations 0..9 cyclically for 20 cycles. Expect fifo_level to stay ≤1, 20 pulses in order, and no drops.
- Clear stall: with 2 packets buffered, assert clear for 1 cycle. Expect no pulse in that cycle, both packets dispatched afterwards, and nothing lost.
- Reset mid-operation: with 5 packets buffered and drop_count=3, assert reset. Expect fifo_level=0, drop_count=0, dispatch_valid=0, and no later dispatch of the flushed packets.
